// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// master: upstream/testbench side driving the instruction and forward sources.
// slave: execute stage consuming them and producing the EX/MEM register outputs.
interface ex_stage_if;
  // ID/EX pipeline inputs
  logic [63:0] EX_R1out;
  logic [63:0] EX_R2out;
  logic [4:0]  EX_rs1;
  logic [4:0]  EX_rs2;
  logic [4:0]  EX_WReg1;
  logic [5:0]  EX_EX_CTRL;
  logic [3:0]  EX_MEM_CTRL;
  logic [2:0]  EX_WB_CTRL;
  logic [11:0] EX_IMM;
  logic        ex_flush;
  // forwarding sources
  logic        fwd_mem_en;
  logic [4:0]  fwd_mem_reg;
  logic [63:0] fwd_mem_data;
  logic        fwd_wb_en;
  logic [4:0]  fwd_wb_reg;
  logic [63:0] fwd_wb_data;
  // outputs
  logic        ex_stall;
  logic [63:0] MEM_ALU_result;
  logic [63:0] MEM_store_data;
  logic [4:0]  MEM_WReg1;
  logic [3:0]  MEM_MEM_CTRL;
  logic [2:0]  MEM_WB_CTRL;

  modport master (
    output EX_R1out, EX_R2out, EX_rs1, EX_rs2, EX_WReg1, EX_EX_CTRL,
           EX_MEM_CTRL, EX_WB_CTRL, EX_IMM, ex_flush,
           fwd_mem_en, fwd_mem_reg, fwd_mem_data,
           fwd_wb_en, fwd_wb_reg, fwd_wb_data,
    input  ex_stall, MEM_ALU_result, MEM_store_data, MEM_WReg1,
           MEM_MEM_CTRL, MEM_WB_CTRL
  );

  modport slave (
    input  EX_R1out, EX_R2out, EX_rs1, EX_rs2, EX_WReg1, EX_EX_CTRL,
           EX_MEM_CTRL, EX_WB_CTRL, EX_IMM, ex_flush,
           fwd_mem_en, fwd_mem_reg, fwd_mem_data,
           fwd_wb_en, fwd_wb_reg, fwd_wb_data,
    output ex_stall, MEM_ALU_result, MEM_store_data, MEM_WReg1,
           MEM_MEM_CTRL, MEM_WB_CTRL
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative radix-2^R multiplier.
// Latency: 1 cycle for ALU ops; 2+64/MUL_RADIX_BITS cycles for MUL.
// Backpressure: ex_stall holds upstream for the start and busy cycles of a multiply.
module ex_stage #(
  parameter int MUL_RADIX_BITS = 2
) (
  input  logic      clk,
  input  logic      reset,
  ex_stage_if.slave bus
);

  localparam int         MUL_ITERS       = 64 / MUL_RADIX_BITS;
  localparam logic [6:0] LAST_ITER       = 7'(MUL_ITERS - 1);
  localparam logic [3:0] BUBBLE_MEM_CTRL = 4'hC;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;

  logic        w_src_imm;
  logic [3:0]  w_alu_op;
  logic [63:0] w_op_a, w_fwd_b, w_op_b, w_imm_sext, w_alu_res;

  logic [63:0] r_mcand, r_mplier, r_acc, w_pp;
  logic [6:0]  r_cnt;

  logic        w_stall, w_ld_alu, w_ld_prod, w_mul_start, w_mul_iter;

  logic [63:0] r_alu_result, r_store_data;
  logic [4:0]  r_wreg;
  logic [3:0]  r_mem_ctrl;
  logic [2:0]  r_wb_ctrl;

  // bit 0 of the EX control field carries no meaning for this stage
  logic        w_unused_ctrl0;
  assign w_unused_ctrl0 = bus.EX_EX_CTRL[0];

  assign w_src_imm  = bus.EX_EX_CTRL[5];
  assign w_alu_op   = bus.EX_EX_CTRL[4:1];
  assign w_imm_sext = {{52{bus.EX_IMM[11]}}, bus.EX_IMM};

  // Forwarding: MEM beats WB, x0 is never forwarded.
  assign w_op_a = (bus.fwd_mem_en && (bus.fwd_mem_reg == bus.EX_rs1) && (bus.EX_rs1 != 5'd0)) ? bus.fwd_mem_data :
                  (bus.fwd_wb_en  && (bus.fwd_wb_reg  == bus.EX_rs1) && (bus.EX_rs1 != 5'd0)) ? bus.fwd_wb_data  :
                  bus.EX_R1out;
  assign w_fwd_b = (bus.fwd_mem_en && (bus.fwd_mem_reg == bus.EX_rs2) && (bus.EX_rs2 != 5'd0)) ? bus.fwd_mem_data :
                   (bus.fwd_wb_en  && (bus.fwd_wb_reg  == bus.EX_rs2) && (bus.EX_rs2 != 5'd0)) ? bus.fwd_wb_data  :
                   bus.EX_R2out;
  // store data always takes the register operand, even for immediate-form ops
  assign w_op_b = w_src_imm ? w_imm_sext : w_fwd_b;

  // Single-cycle ALU; MUL and undefined opcodes yield 0 here.
  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      OP_ADD:  w_alu_res = w_op_a + w_op_b;
      OP_SUB:  w_alu_res = w_op_a - w_op_b;
      OP_AND:  w_alu_res = w_op_a & w_op_b;
      OP_OR:   w_alu_res = w_op_a | w_op_b;
      OP_XOR:  w_alu_res = w_op_a ^ w_op_b;
      OP_SLL:  w_alu_res = w_op_a << w_op_b[5:0];
      OP_SRL:  w_alu_res = w_op_a >> w_op_b[5:0];
      OP_SLT:  w_alu_res = {63'd0, ($signed(w_op_a) < $signed(w_op_b))};
      default: w_alu_res = '0;
    endcase
  end

  // Partial product for the low MUL_RADIX_BITS multiplier bits of this iteration.
  always_comb begin
    w_pp = '0;
    for (int k = 0; k < MUL_RADIX_BITS; k++) begin
      if (r_mplier[k]) w_pp = w_pp + (r_mcand << k);
    end
  end

  // Multiply sequencing, stall generation and EX/MEM load selection.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_ld_alu    = 1'b0;
    w_ld_prod   = 1'b0;
    w_mul_start = 1'b0;
    w_mul_iter  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ex_flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_alu_op == OP_MUL) begin
          w_stall     = 1'b1;
          w_mul_start = 1'b1;
          w_state_nxt = S_BUSY;
        end else begin
          w_ld_alu    = 1'b1;
        end
      end
      S_BUSY: begin
        if (bus.ex_flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_stall    = 1'b1;
          w_mul_iter = 1'b1;
          if (r_cnt == LAST_ITER) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (!bus.ex_flush) w_ld_prod = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.ex_stall = w_stall & ~reset;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Shift-and-add multiplier datapath: multiplicand moves left, multiplier right.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= w_op_a;
      r_mplier <= w_op_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_mul_iter) begin
      r_acc    <= r_acc + w_pp;
      r_mcand  <= r_mcand << MUL_RADIX_BITS;
      r_mplier <= r_mplier >> MUL_RADIX_BITS;
      r_cnt    <= r_cnt + 7'd1;
    end
  end

  // EX/MEM register: ALU result, finished product, or bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_wreg       <= '0;
      r_mem_ctrl   <= BUBBLE_MEM_CTRL;
      r_wb_ctrl    <= '0;
    end else if (w_ld_alu || w_ld_prod) begin
      r_alu_result <= w_ld_prod ? r_acc : w_alu_res;
      r_store_data <= w_fwd_b;
      r_wreg       <= bus.EX_WReg1;
      r_mem_ctrl   <= bus.EX_MEM_CTRL;
      r_wb_ctrl    <= bus.EX_WB_CTRL;
    end else begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_wreg       <= '0;
      r_mem_ctrl   <= BUBBLE_MEM_CTRL;
      r_wb_ctrl    <= '0;
    end
  end

  assign bus.MEM_ALU_result = r_alu_result;
  assign bus.MEM_store_data = r_store_data;
  assign bus.MEM_WReg1      = r_wreg;
  assign bus.MEM_MEM_CTRL   = r_mem_ctrl;
  assign bus.MEM_WB_CTRL    = r_wb_ctrl;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed vectors, an abstract per-instruction model
// checked every cycle on the falling edge, plus hand-computed literal checks.
module tb_ex_stage;

  localparam int RADIX = 2;
  localparam int NIT   = 64 / RADIX;

  logic clk;
  logic reset;
  ex_stage_if bus ();

  ex_stage #(.MUL_RADIX_BITS(RADIX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] fwd_val(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd0)                                 return rf;
    if (bus.fwd_mem_en && bus.fwd_mem_reg == rs)    return bus.fwd_mem_data;
    if (bus.fwd_wb_en && bus.fwd_wb_reg == rs)      return bus.fwd_wb_data;
    return rf;
  endfunction

  function automatic logic [63:0] alu_val(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[5:0];
      4'd6: return a >> b[5:0];
      4'd7: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  logic        m_valid = 1'b0;
  int          m_cyc   = 0;   // cycles a multiply has occupied EX so far (0 = none)
  logic [63:0] m_a, m_b;
  logic [63:0] e_res, e_store;
  logic [4:0]  e_wreg;
  logic [3:0]  e_mem;
  logic [2:0]  e_wb;

  // Expected EX/MEM contents after each rising edge.
  always @(posedge clk) begin
    logic [63:0] a, b, bp;
    logic [3:0]  op;
    a  = fwd_val(bus.EX_rs1, bus.EX_R1out);
    b  = fwd_val(bus.EX_rs2, bus.EX_R2out);
    bp = bus.EX_EX_CTRL[5] ? {{52{bus.EX_IMM[11]}}, bus.EX_IMM} : b;
    op = bus.EX_EX_CTRL[4:1];
    m_valid = 1'b1;
    e_res = 64'd0; e_store = 64'd0; e_wreg = 5'd0; e_mem = 4'hC; e_wb = 3'd0;
    if (reset || bus.ex_flush) begin
      m_cyc = 0;
    end else if (m_cyc == 0 && op != 4'd8) begin
      e_res = alu_val(op, a, bp);
      e_store = b; e_wreg = bus.EX_WReg1; e_mem = bus.EX_MEM_CTRL; e_wb = bus.EX_WB_CTRL;
    end else if (m_cyc == NIT + 1) begin
      e_res = m_a * m_b;
      e_store = b; e_wreg = bus.EX_WReg1; e_mem = bus.EX_MEM_CTRL; e_wb = bus.EX_WB_CTRL;
      m_cyc = 0;
    end else begin
      if (m_cyc == 0) begin
        m_a = a;
        m_b = bp;
      end
      m_cyc++;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic exp_stall;
    if (m_valid) begin
      exp_stall = !reset && !bus.ex_flush &&
                  ((m_cyc > 0) ? (m_cyc <= NIT) : (bus.EX_EX_CTRL[4:1] == 4'd8));
      check("model_stall",  64'(bus.ex_stall),       64'(exp_stall));
      check("model_result", bus.MEM_ALU_result,      e_res);
      check("model_store",  bus.MEM_store_data,      e_store);
      check("model_wreg",   64'(bus.MEM_WReg1),      64'(e_wreg));
      check("model_memctl", 64'(bus.MEM_MEM_CTRL),   64'(e_mem));
      check("model_wbctl",  64'(bus.MEM_WB_CTRL),    64'(e_wb));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bit 0 of EX_EX_CTRL is set to show it has no effect
  task automatic set_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic imm_sel, input logic [11:0] imm);
    bus.EX_EX_CTRL = {imm_sel, op, 1'b1};
    bus.EX_R1out   = a;
    bus.EX_R2out   = b;
    bus.EX_IMM     = imm;
  endtask

  // Called just after MUL operands are applied; counts stall cycles and checks the product.
  task automatic run_mul(input logic [63:0] exp);
    int cnt, bad;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.ex_stall) break;
      if (cnt > 0 && bus.MEM_MEM_CTRL != 4'hC) bad++;
      cnt++;
    end
    check("mul_stall_cycles", 64'(cnt), 64'd33);
    check("mul_bubbles", 64'(bad), 64'd0);
    step();
    check("mul_result", bus.MEM_ALU_result, exp);
    check("mul_wreg", 64'(bus.MEM_WReg1), 64'(bus.EX_WReg1));
  endtask

  logic [3:0]  t_op [10];
  logic [63:0] t_a  [10];
  logic [63:0] t_b  [10];
  logic [63:0] t_r  [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.EX_R1out = '0; bus.EX_R2out = '0; bus.EX_rs1 = '0; bus.EX_rs2 = '0;
    bus.EX_WReg1 = 5'd7; bus.EX_EX_CTRL = '0; bus.EX_MEM_CTRL = 4'h3;
    bus.EX_WB_CTRL = 3'b101; bus.EX_IMM = '0; bus.ex_flush = 1'b0;
    bus.fwd_mem_en = 1'b0; bus.fwd_mem_reg = '0; bus.fwd_mem_data = '0;
    bus.fwd_wb_en = 1'b0; bus.fwd_wb_reg = '0; bus.fwd_wb_data = '0;

    step(); step();
    check("reset_memctl", 64'(bus.MEM_MEM_CTRL), 64'hC);
    check("reset_result", bus.MEM_ALU_result, 64'd0);
    check("reset_stall", 64'(bus.ex_stall), 64'd0);
    reset = 1'b0;

    // ADD with negative immediate: 5 + (-1) = 4
    set_op(4'd0, 64'd5, 64'hAA, 1'b1, 12'hFFF);
    step();
    check("add_imm_result", bus.MEM_ALU_result, 64'd4);
    check("add_imm_store", bus.MEM_store_data, 64'hAA);
    check("add_imm_wbctl", 64'(bus.MEM_WB_CTRL), 64'd5);
    check("add_imm_memctl", 64'(bus.MEM_MEM_CTRL), 64'd3);

    // forwarding priority
    bus.fwd_mem_en = 1'b1; bus.fwd_mem_reg = 5'd3; bus.fwd_mem_data = 64'h10;
    bus.fwd_wb_en  = 1'b1; bus.fwd_wb_reg  = 5'd3; bus.fwd_wb_data  = 64'h20;
    bus.EX_rs1 = 5'd3;
    set_op(4'd0, 64'h30, 64'd0, 1'b1, 12'd1);
    step();
    check("fwd_mem_priority", bus.MEM_ALU_result, 64'h11);
    bus.EX_rs1 = 5'd0;
    step();
    check("fwd_x0_never", bus.MEM_ALU_result, 64'h31);
    bus.EX_rs1 = 5'd3; bus.fwd_mem_en = 1'b0;
    step();
    check("fwd_wb_only", bus.MEM_ALU_result, 64'h21);
    bus.EX_rs1 = 5'd0; bus.EX_rs2 = 5'd3; bus.fwd_mem_en = 1'b1;
    set_op(4'd0, 64'd1, 64'h99, 1'b1, 12'd2);
    step();
    check("fwd_store_data", bus.MEM_store_data, 64'h10);
    check("imm_not_store", bus.MEM_ALU_result, 64'd3);
    bus.EX_rs2 = 5'd0; bus.fwd_mem_en = 1'b0; bus.fwd_wb_en = 1'b0;

    // ALU operation table
    t_op[0] = 4'd0; t_a[0] = 64'd7;   t_b[0] = 64'd8;   t_r[0] = 64'd15;
    t_op[1] = 4'd1; t_a[1] = 64'd3;   t_b[1] = 64'd5;   t_r[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    t_op[2] = 4'd2; t_a[2] = 64'hF0; t_b[2] = 64'h3C; t_r[2] = 64'h30;
    t_op[3] = 4'd3; t_a[3] = 64'hF0; t_b[3] = 64'h3C; t_r[3] = 64'hFC;
    t_op[4] = 4'd4; t_a[4] = 64'hF0; t_b[4] = 64'h3C; t_r[4] = 64'hCC;
    t_op[5] = 4'd5; t_a[5] = 64'd1;   t_b[5] = 64'h44; t_r[5] = 64'h10;
    t_op[6] = 4'd6; t_a[6] = 64'h8000_0000_0000_0000; t_b[6] = 64'd63; t_r[6] = 64'd1;
    t_op[7] = 4'd7; t_a[7] = 64'd5;   t_b[7] = 64'd7;   t_r[7] = 64'd1;
    t_op[8] = 4'd7; t_a[8] = 64'd7;   t_b[8] = 64'd5;   t_r[8] = 64'd0;
    t_op[9] = 4'd9; t_a[9] = 64'd7;   t_b[9] = 64'd5;   t_r[9] = 64'd0;
    for (int i = 0; i < 10; i++) begin
      set_op(t_op[i], t_a[i], t_b[i], 1'b0, 12'd0);
      step();
      check($sformatf("alu_table_%0d", i), bus.MEM_ALU_result, t_r[i]);
    end

    // multiply, then back-to-back multiply
    bus.EX_WReg1 = 5'd9;
    set_op(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 12'd0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFD);
    set_op(4'd8, 64'd7, 64'd6, 1'b0, 12'd0);
    run_mul(64'd42);

    // flush at busy iteration 10
    set_op(4'd8, 64'd5, 64'd6, 1'b0, 12'd0);
    step();
    repeat (10) step();
    bus.ex_flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(bus.ex_stall), 64'd0);
    step();
    check("flush_bubble_ctl", 64'(bus.MEM_MEM_CTRL), 64'hC);
    check("flush_bubble_wreg", 64'(bus.MEM_WReg1), 64'd0);
    bus.ex_flush = 1'b0;
    set_op(4'd0, 64'd2, 64'd3, 1'b0, 12'd0);
    @(negedge clk);
    check("post_flush_stall", 64'(bus.ex_stall), 64'd0);
    step();
    check("post_flush_add", bus.MEM_ALU_result, 64'd5);

    // flush dominates a multiply start
    set_op(4'd8, 64'd5, 64'd6, 1'b0, 12'd0);
    bus.ex_flush = 1'b1;
    @(negedge clk);
    check("flush_vs_start_stall", 64'(bus.ex_stall), 64'd0);
    step();
    bus.ex_flush = 1'b0;
    set_op(4'd1, 64'd10, 64'd4, 1'b0, 12'd0);
    step();
    check("flush_vs_start_sub", bus.MEM_ALU_result, 64'd6);

    // reset mid-multiply, dominating flush
    set_op(4'd8, 64'd9, 64'd9, 1'b0, 12'd0);
    repeat (5) step();
    reset = 1'b1;
    bus.ex_flush = 1'b1;
    @(negedge clk);
    check("reset_mid_stall", 64'(bus.ex_stall), 64'd0);
    step();
    check("reset_mid_ctl", 64'(bus.MEM_MEM_CTRL), 64'hC);
    check("reset_mid_result", bus.MEM_ALU_result, 64'd0);
    reset = 1'b0;
    bus.ex_flush = 1'b0;
    set_op(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 12'd0);
    step();
    check("slt_after_reset", bus.MEM_ALU_result, 64'd1);

    // immediate-operand multiply after reset: 4 * (-2) = -8
    set_op(4'd8, 64'd4, 64'd0, 1'b1, 12'hFFE);
    run_mul(64'hFFFF_FFFF_FFFF_FFF8);

    set_op(4'd0, 64'd0, 64'd0, 1'b0, 12'd0);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
